// File: rtl/transchroma_pkg.sv
// Shared constants and elaboration-time LUT generators for the luma-dependent chroma transform.
// Widths are held in hundredths so the table generators stay in integer arithmetic.
package transchroma_pkg;

    localparam int MEAN_KH_CB = 108;
    localparam int MEAN_LO_CB = 118;
    localparam int MEAN_HI_CB = 118;
    localparam int MEAN_KH_CR = 154;
    localparam int MEAN_LO_CR = 144;
    localparam int MEAN_HI_CR = 132;

    localparam int WC_CB_X100 = 4697;
    localparam int WL_CB_X100 = 2300;
    localparam int WH_CB_X100 = 1400;
    localparam int WC_CR_X100 = 3876;
    localparam int WL_CR_X100 = 2000;
    localparam int WH_CR_X100 = 1000;

    localparam int ST_S0    = 0;
    localparam int ST_S1    = 1;
    localparam int ST_S2    = 2;
    localparam int ST_S3    = 3;
    localparam int ST_S4    = 4;
    localparam int N_STAGES = 5;

    function automatic int clamp_y(input int y, input int y_min, input int y_max);
        if (y < y_min) return y_min;
        if (y > y_max) return y_max;
        return y;
    endfunction

    // Mean moves linearly from its K_H anchor to the extreme anchor at Y_MIN / Y_MAX.
    function automatic int lut_mean(input int sel, input int y, input int k_l, input int k_h,
                                    input int y_min, input int y_max);
        int yc, mkh, a_lo, a_hi;
        yc   = clamp_y(y, y_min, y_max);
        mkh  = (sel != 0) ? MEAN_KH_CR : MEAN_KH_CB;
        a_lo = (sel != 0) ? MEAN_LO_CR : MEAN_LO_CB;
        a_hi = (sel != 0) ? MEAN_HI_CR : MEAN_HI_CB;
        if (yc < k_l) return mkh + ((a_lo - mkh) * (k_l - yc)) / (k_l - y_min);
        if (yc > k_h) return mkh + ((a_hi - mkh) * (yc - k_h)) / (y_max - k_h);
        return mkh;
    endfunction

    function automatic int lut_ratio(input int sel, input int y, input int k_l, input int k_h,
                                     input int y_min, input int y_max, input int frac_w);
        int yc, wc, wl, wh, w;
        yc = clamp_y(y, y_min, y_max);
        wc = (sel != 0) ? WC_CR_X100 : WC_CB_X100;
        wl = (sel != 0) ? WL_CR_X100 : WL_CB_X100;
        wh = (sel != 0) ? WH_CR_X100 : WH_CB_X100;
        if (yc < k_l)
            w = wl + ((yc - y_min) * (wc - wl)) / (k_l - y_min);
        else if (yc > k_h)
            w = wh + ((y_max - yc) * (wc - wh)) / (y_max - k_h);
        else
            return 1 << frac_w;
        return (wc << frac_w) / w;
    endfunction

endpackage

// File: rtl/transchroma_pipe_lut.sv
// Per-channel mean and width-ratio ROM indexed by clamped luma; contents fixed at elaboration.
module chroma_lut
    import transchroma_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int FRAC_W = 8,
    parameter int K_L    = 125,
    parameter int K_H    = 188,
    parameter int Y_MIN  = 16,
    parameter int Y_MAX  = 235
) (
    input  logic              i_sel,
    input  logic [DATA_W-1:0] i_y,
    output logic [DATA_W-1:0] o_mean,
    output logic [FRAC_W+3:0] o_ratio
);

    localparam int N_Y = 1 << DATA_W;
    localparam int RW  = FRAC_W + 4;

    logic [DATA_W-1:0] w_mean_tab  [2][N_Y];
    logic [RW-1:0]     w_ratio_tab [2][N_Y];

    for (genvar s = 0; s < 2; s++) begin : g_sel
        for (genvar y = 0; y < N_Y; y++) begin : g_y
            localparam int MEAN  = lut_mean(s, y, K_L, K_H, Y_MIN, Y_MAX);
            localparam int RATIO = lut_ratio(s, y, K_L, K_H, Y_MIN, Y_MAX, FRAC_W);
            assign w_mean_tab[s][y]  = DATA_W'(MEAN);
            assign w_ratio_tab[s][y] = RW'(RATIO);
        end
    end

    assign o_mean  = w_mean_tab[i_sel][i_y];
    assign o_ratio = w_ratio_tab[i_sel][i_y];

endmodule

// File: rtl/transchroma_pipe.sv
// Five-stage Cb/Cr luma-dependent transform with valid/ready flow control, rounding and saturation.
// One global advance enable stalls every stage together whenever the output is held.
module transchroma_pipe
    import transchroma_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int FRAC_W = 8,
    parameter int K_L    = 125,
    parameter int K_H    = 188,
    parameter int Y_MIN  = 16,
    parameter int Y_MAX  = 235
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_sel,
    input  logic [DATA_W-1:0] in_c,
    input  logic [DATA_W-1:0] in_y,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_sel,
    output logic [DATA_W-1:0] out_c,
    output logic              out_bypass
);

    localparam int RW = FRAC_W + 4;
    localparam int PW = DATA_W + 1 + RW;

    localparam logic [DATA_W-1:0]    Y_MIN_V = DATA_W'(Y_MIN);
    localparam logic [DATA_W-1:0]    Y_MAX_V = DATA_W'(Y_MAX);
    localparam logic [DATA_W-1:0]    K_L_V   = DATA_W'(K_L);
    localparam logic [DATA_W-1:0]    K_H_V   = DATA_W'(K_H);
    localparam logic signed [PW-1:0] RND     = PW'(1 << (FRAC_W - 1));
    localparam logic signed [PW-1:0] SAT_MAX = PW'((1 << DATA_W) - 1);
    localparam logic signed [PW-1:0] MKH_CB  = PW'(MEAN_KH_CB);
    localparam logic signed [PW-1:0] MKH_CR  = PW'(MEAN_KH_CR);

    logic [N_STAGES-1:0] r_vld;
    logic                w_adv;

    logic                     r_sel0, r_sel1, r_sel2, r_sel3;
    logic [DATA_W-1:0]        r_c0, r_c1, r_c2, r_c3;
    logic [DATA_W-1:0]        r_y0;
    logic [DATA_W-1:0]        r_mean1;
    logic [RW-1:0]            r_ratio1, r_ratio2;
    logic                     r_byp1, r_byp2, r_byp3;
    logic signed [DATA_W:0]   r_diff2;
    logic signed [PW-1:0]     r_prod3;
    logic                     r_out_sel, r_out_byp;
    logic [DATA_W-1:0]        r_out_c;

    logic [DATA_W-1:0]    w_y_clamp;
    logic [DATA_W-1:0]    w_mean;
    logic [RW-1:0]        w_ratio;
    logic                 w_byp;
    logic signed [PW-1:0] w_sum, w_shift, w_val;
    logic [DATA_W-1:0]    w_sat;

    assign w_adv    = !r_vld[ST_S4] || out_ready;
    assign in_ready = w_adv;

    // Bypass uses the raw registered luma; the clamp only steers the table lookup.
    assign w_y_clamp = (r_y0 < Y_MIN_V) ? Y_MIN_V : ((r_y0 > Y_MAX_V) ? Y_MAX_V : r_y0);
    assign w_byp     = (r_y0 >= K_L_V) && (r_y0 <= K_H_V);

    chroma_lut #(
        .DATA_W (DATA_W),
        .FRAC_W (FRAC_W),
        .K_L    (K_L),
        .K_H    (K_H),
        .Y_MIN  (Y_MIN),
        .Y_MAX  (Y_MAX)
    ) u_lut (
        .i_sel   (r_sel0),
        .i_y     (w_y_clamp),
        .o_mean  (w_mean),
        .o_ratio (w_ratio)
    );

    always_comb begin
        w_sum   = r_prod3 + RND;
        w_shift = w_sum >>> FRAC_W;
        w_val   = w_shift + (r_sel3 ? MKH_CR : MKH_CB);
        if (w_val[PW-1])
            w_sat = '0;
        else if (w_val > SAT_MAX)
            w_sat = '1;
        else
            w_sat = w_val[DATA_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_vld     <= '0;
            r_out_c   <= '0;
            r_out_sel <= 1'b0;
            r_out_byp <= 1'b0;
        end else if (w_adv) begin
            r_vld[ST_S0] <= in_valid;
            r_vld[ST_S1] <= r_vld[ST_S0];
            r_vld[ST_S2] <= r_vld[ST_S1];
            r_vld[ST_S3] <= r_vld[ST_S2];
            r_vld[ST_S4] <= r_vld[ST_S3];

            r_sel0 <= in_sel;
            r_c0   <= in_c;
            r_y0   <= in_y;

            r_sel1   <= r_sel0;
            r_c1     <= r_c0;
            r_mean1  <= w_mean;
            r_ratio1 <= w_ratio;
            r_byp1   <= w_byp;

            r_sel2   <= r_sel1;
            r_c2     <= r_c1;
            r_ratio2 <= r_ratio1;
            r_byp2   <= r_byp1;
            r_diff2  <= $signed({1'b0, r_c1}) - $signed({1'b0, r_mean1});

            r_sel3  <= r_sel2;
            r_c3    <= r_c2;
            r_byp3  <= r_byp2;
            r_prod3 <= PW'(r_diff2) * PW'($signed({1'b0, r_ratio2}));

            r_out_sel <= r_sel3;
            r_out_byp <= r_byp3;
            r_out_c   <= r_byp3 ? r_c3 : w_sat;
        end
    end

    assign out_valid  = r_vld[ST_S4];
    assign out_sel    = r_out_sel;
    assign out_c      = r_out_c;
    assign out_bypass = r_out_byp;

endmodule

// File: tb/tb_transchroma_pipe.sv
// Directed and backpressure bench for transchroma_pipe with a behavioural reference of the transform.
module tb_transchroma_pipe;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic       in_sel;
    logic [7:0] in_c;
    logic [7:0] in_y;
    logic       out_valid;
    logic       out_ready;
    logic       out_sel;
    logic [7:0] out_c;
    logic       out_bypass;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    transchroma_pipe dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sel     (in_sel),
        .in_c       (in_c),
        .in_y       (in_y),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_sel    (out_sel),
        .out_c      (out_c),
        .out_bypass (out_bypass)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference transform: Hsu luma-dependent mean/width, widths in hundredths, ratio in Q.8.
    function automatic void model(input int sel, input int y, input int c,
                                  output int oc, output int ob);
        int yc, wc, wl, wh, mkh, alo, ahi, w, m, ratio, p, v;
        if (y >= 125 && y <= 188) begin
            oc = c;
            ob = 1;
            return;
        end
        ob  = 0;
        yc  = (y < 16) ? 16 : ((y > 235) ? 235 : y);
        wc  = sel ? 3876 : 4697;
        wl  = sel ? 2000 : 2300;
        wh  = sel ? 1000 : 1400;
        mkh = sel ? 154 : 108;
        alo = sel ? 144 : 118;
        ahi = sel ? 132 : 118;
        if (yc < 125) begin
            w = wl + ((yc - 16) * (wc - wl)) / 109;
            m = mkh + ((alo - mkh) * (125 - yc)) / 109;
        end else begin
            w = wh + ((235 - yc) * (wc - wh)) / 47;
            m = mkh + ((ahi - mkh) * (yc - 188)) / 47;
        end
        ratio = (wc * 256) / w;
        p = (c - m) * ratio;
        v = ((p + 128) >>> 8) + mkh;
        oc = (v < 0) ? 0 : ((v > 255) ? 255 : v);
    endfunction

    task automatic run_vec(input string tag, input bit sel, input int y, input int c,
                           input int exp_c, input bit exp_byp);
        int lat;
        @(negedge clk);
        in_valid  = 1'b1;
        in_sel    = sel;
        in_y      = 8'(y);
        in_c      = 8'(c);
        out_ready = 1'b1;
        #1;
        chk({tag, ".in_ready"}, in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 12) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, ".latency"}, lat, 5);
        chk({tag, ".out_c"}, out_c, exp_c);
        chk({tag, ".bypass"}, out_bypass, exp_byp);
        chk({tag, ".sel"}, out_sel, sel);
    endtask

    initial begin
        int q_exp[$];
        int sent, rcvd, cyc, oc, ob, hits, exp_word;
        logic [7:0] bp_y [32];
        logic [7:0] bp_c [32];

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_sel    = 1'b0;
        in_c      = '0;
        in_y      = '0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst.out_valid", out_valid, 0);
        chk("rst.out_c", out_c, 0);
        chk("rst.out_sel", out_sel, 0);
        chk("rst.out_bypass", out_bypass, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst.in_ready", in_ready, 1);

        run_vec("bypass",    1'b1, 150,  77,  77, 1'b1);
        run_vec("mean_cr",   1'b1,  16, 144, 154, 1'b0);
        run_vec("mean_cb",   1'b0,  16, 118, 108, 1'b0);
        run_vec("sat_hi",    1'b1,  16, 255, 255, 1'b0);
        run_vec("sat_lo",    1'b1,  16,   0,   0, 1'b0);
        run_vec("y124",      1'b1, 124,  10,   9, 1'b0);
        run_vec("y125",      1'b0, 125,  10,  10, 1'b1);
        run_vec("y188",      1'b1, 188, 200, 200, 1'b1);
        run_vec("y189",      1'b0, 189,  10,   9, 1'b0);
        run_vec("y5_clamp",  1'b1,   5, 144, 154, 1'b0);
        run_vec("y235",      1'b0, 235, 130, 148, 1'b0);
        run_vec("y250_clamp",1'b0, 250, 130, 148, 1'b0);

        // Backpressure: interleaved Cb/Cr with random valid/ready.
        for (int i = 0; i < 32; i++) begin
            bp_y[i] = 8'($urandom_range(255));
            bp_c[i] = 8'($urandom_range(255));
        end
        sent = 0;
        rcvd = 0;
        cyc  = 0;
        while (rcvd < 32 && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            in_valid  = (sent < 32) && ($urandom_range(1) == 1);
            in_sel    = sent[0];
            in_y      = bp_y[sent % 32];
            in_c      = bp_c[sent % 32];
            out_ready = ($urandom_range(1) == 1);
            #1;
            chk("bp.in_ready", in_ready, !(out_valid && !out_ready));
            if (out_valid && out_ready) begin
                if (q_exp.size() == 0) begin
                    chk("bp.extra_out", 1, 0);
                end else begin
                    exp_word = q_exp.pop_front();
                    chk("bp.out_word", {22'd0, out_sel, out_bypass, out_c}, exp_word);
                end
                rcvd++;
            end
            if (in_valid && in_ready) begin
                model(int'(in_sel), int'(in_y), int'(in_c), oc, ob);
                q_exp.push_back({in_sel, ob[0], oc[7:0]});
                sent++;
            end
        end
        chk("bp.count", rcvd, 32);
        chk("bp.queue_empty", q_exp.size(), 0);

        // Reset with three samples in flight.
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_sel   = 1'b1;
            in_y     = 8'd16;
            in_c     = 8'(100 + i);
            @(negedge clk);
        end
        in_valid = 1'b0;
        rst_n    = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("flush.out_valid", out_valid, 0);
        hits = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (out_valid) hits++;
        end
        chk("flush.stale", hits, 0);
        run_vec("post_rst", 1'b0, 16, 118, 108, 1'b0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
